// File: rtl/alu_sig_analyzer_pkg.sv
// Shared constants, state encoding and input-word formation for the ALU
// signature analyzer.
package alu_sig_analyzer_pkg;

  localparam int DATA_W = 16;
  localparam int FUNC_W = 3;
  localparam int CNT_W  = 9;

  localparam logic [DATA_W-1:0] DEF_SEED = 16'hFFFF;
  localparam logic [DATA_W-1:0] DEF_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Fold function code and zero flag into the result so both are covered by the signature.
  function automatic logic [DATA_W-1:0] mix_word(input logic [DATA_W-1:0] result,
                                                 input logic              zf,
                                                 input logic [FUNC_W-1:0] fn);
    return result ^ {fn, 12'h000, zf};
  endfunction

endpackage

// File: rtl/alu_sig_analyzer_misr16_step.sv
// One combinational MISR step: shift left, conditional polynomial feedback,
// then fold in the new data word.
module misr16_step
  import alu_sig_analyzer_pkg::*;
#(
  parameter logic [DATA_W-1:0] POLY = DEF_POLY
) (
  input  logic [DATA_W-1:0] sig,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] sig_next
);

  assign sig_next = {sig[DATA_W-2:0], 1'b0} ^ (sig[DATA_W-1] ? POLY : '0) ^ d;

endmodule

// File: rtl/alu_sig_analyzer.sv
// Captures a run of ALU samples into a 16-bit MISR and compares the final
// signature against a golden value latched at start.
module alu_sig_analyzer
  import alu_sig_analyzer_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = DEF_SEED,
  parameter logic [DATA_W-1:0] POLY = DEF_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        num_vec,
  input  logic [DATA_W-1:0] golden_sig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zf,
  input  logic [FUNC_W-1:0] func,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] signature,
  output logic [CNT_W-1:0]  sample_cnt
);

  state_t            state, state_next;
  logic [DATA_W-1:0] golden_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] d, sig_next;
  logic              accept, last;

  assign d      = mix_word(alu_result, alu_zf, func);
  assign accept = (state == RUN) && sample_valid;
  assign last   = accept && ((sample_cnt + 9'd1) == count_q);

  misr16_step #(.POLY(POLY)) u_step (
    .sig      (signature),
    .d        (d),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // pass is resolved on the final sample edge so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signature  <= SEED;
      sample_cnt <= '0;
      pass       <= 1'b0;
      golden_q   <= '0;
      count_q    <= '0;
    end else if ((state == IDLE) && start) begin
      signature  <= SEED;
      sample_cnt <= '0;
      pass       <= 1'b0;
      golden_q   <= golden_sig;
      count_q    <= (num_vec == 8'd0) ? 9'd256 : {1'b0, num_vec};
    end else if (accept) begin
      signature  <= sig_next;
      sample_cnt <= sample_cnt + 9'd1;
      if (last) pass <= (sig_next == golden_q);
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == CHECK);

endmodule

// File: tb/tb_alu_sig_analyzer.sv
// Bench for alu_sig_analyzer: single-sample vector table plus multi-cycle
// sequences, with expected run results queued and checked on done.
module tb_alu_sig_analyzer;
  import alu_sig_analyzer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_vec = '0;
  logic [15:0] golden_sig = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] alu_result = '0;
  logic        alu_zf = 1'b0;
  logic [2:0]  func = '0;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [8:0]  sample_cnt;

  alu_sig_analyzer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .golden_sig(golden_sig), .sample_valid(sample_valid),
    .alu_result(alu_result), .alu_zf(alu_zf), .func(func),
    .busy(busy), .done(done), .pass(pass),
    .signature(signature), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int dcnt  = 0;

  typedef struct { logic [15:0] sig; logic pass; logic [8:0] cnt; } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0] res; logic zf; logic [2:0] fn;
    logic [15:0] gold; logic [15:0] exp_sig; logic exp_pass;
  } vec_t;
  vec_t tv[6];

  logic [15:0] m_sig, m_gold;
  int          m_cnt, m_target;
  bit          m_active = 0;

  function automatic logic [15:0] step(input logic [15:0] s, input logic [15:0] dw);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'h1021;
    return t ^ dw;
  endfunction

  function automatic logic [15:0] dword(input logic [15:0] r, input logic z, input logic [2:0] f);
    return r ^ {f, 12'h000, z};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      dcnt++;
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no run completion at %0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_signature", signature, e.sig);
        chk("sb_pass", pass, e.pass);
        chk("sb_sample_cnt", sample_cnt, e.cnt);
      end
    end
  end

  task automatic do_start(input logic [7:0] nv, input logic [15:0] g);
    @(negedge clk);
    start = 1'b1; num_vec = nv; golden_sig = g; sample_valid = 1'b0;
    m_sig = 16'hFFFF; m_cnt = 0; m_target = (nv == 0) ? 256 : int'(nv);
    m_gold = g; m_active = 1;
    @(negedge clk);
    start = 1'b0; golden_sig = 16'($urandom); num_vec = 8'($urandom);
  endtask

  task automatic put(input logic [15:0] r, input logic z, input logic [2:0] f);
    @(negedge clk);
    sample_valid = 1'b1; alu_result = r; alu_zf = z; func = f;
    if (m_active) begin
      m_sig = step(m_sig, dword(r, z, f));
      m_cnt++;
      if (m_cnt == m_target) begin
        sbq.push_back('{m_sig, (m_sig == m_gold), 9'(m_cnt)});
        m_active = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] g;
    logic [15:0] rr[257];
    logic        zz[257];
    logic [2:0]  ff[257];
    int          d0;

    tv[0] = '{16'h0002, 1'b0, 3'd0, 16'hEFDD, 16'hEFDD, 1'b1};
    tv[1] = '{16'h0000, 1'b1, 3'd1, 16'hCFDE, 16'hCFDE, 1'b1};
    tv[2] = '{16'h0000, 1'b1, 3'd1, 16'hCFDF, 16'hCFDE, 1'b0};
    tv[3] = '{16'hFFFF, 1'b0, 3'd0, 16'h1020, 16'h1020, 1'b1};
    tv[4] = '{16'h1234, 1'b1, 3'd7, 16'h1DEA, 16'h1DEA, 1'b1};
    tv[5] = '{16'h0000, 1'b0, 3'd0, 16'h0000, 16'hEFDF, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", signature, 16'hFFFF);
    chk("rst_cnt", sample_cnt, 0);
    rst_n = 1'b1;

    // samples in IDLE are ignored
    put(16'h5555, 1'b1, 3'd3);
    idle(2);
    chk("idle_ignore_sig", signature, 16'hFFFF);
    chk("idle_ignore_cnt", sample_cnt, 0);

    // single-sample table
    for (int i = 0; i < 6; i++) begin
      do_start(8'd1, tv[i].gold);
      put(tv[i].res, tv[i].zf, tv[i].fn);
      idle(1);
      chk("t_done_next_cycle", done, 1);
      chk("t_sig", signature, tv[i].exp_sig);
      chk("t_pass", pass, tv[i].exp_pass);
      idle(1);
      chk("t_done_one_cycle", done, 0);
      chk("t_busy_idle", busy, 0);
      chk("t_pass_hold", pass, tv[i].exp_pass);
      chk("t_sig_hold", signature, tv[i].exp_sig);
    end

    // gap of 3 invalid cycles between two samples
    g = step(step(16'hFFFF, dword(16'hA5A5, 1'b0, 3'd2)), dword(16'h0F0F, 1'b1, 3'd5));
    do_start(8'd2, g);
    put(16'hA5A5, 1'b0, 3'd2);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("gap_cnt", sample_cnt, 1);
      chk("gap_done", done, 0);
      chk("gap_busy", busy, 1);
    end
    put(16'h0F0F, 1'b1, 3'd5);
    idle(1);
    chk("gap_done_after_2nd", done, 1);
    chk("gap_pass", pass, 1);

    // start mid-run with a different golden is ignored
    g = step(step(step(16'hFFFF, dword(16'h1111, 1'b0, 3'd4)),
                  dword(16'h2222, 1'b1, 3'd6)), dword(16'h3333, 1'b0, 3'd1));
    do_start(8'd3, g);
    put(16'h1111, 1'b0, 3'd4);
    @(negedge clk);
    sample_valid = 1'b0; start = 1'b1; golden_sig = ~g; num_vec = 8'd1;
    chk("mid_busy0", busy, 1);
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy1", busy, 1);
    chk("mid_cnt", sample_cnt, 1);
    put(16'h2222, 1'b1, 3'd6);
    idle(1);
    chk("mid_busy2", busy, 1);
    chk("mid_no_done", done, 0);
    put(16'h3333, 1'b0, 3'd1);
    idle(1);
    chk("mid_done", done, 1);
    chk("mid_pass", pass, 1);
    chk("mid_sig", signature, g);

    // reset aborts a run
    do_start(8'd4, 16'h1234);
    put(16'hBEEF, 1'b0, 3'd2);
    idle(1);
    chk("abort_busy_before", busy, 1);
    chk("abort_cnt_before", sample_cnt, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_active = 0;
    chk("abort_busy", busy, 0);
    chk("abort_sig", signature, 16'hFFFF);
    chk("abort_cnt", sample_cnt, 0);
    chk("abort_done", done, 0);
    d0 = dcnt;
    idle(6);
    chk("abort_no_done", dcnt - d0, 0);

    // num_vec=0 runs 256 samples; a 257th is ignored
    g = 16'hFFFF;
    for (int k = 0; k < 257; k++) begin
      rr[k] = 16'($urandom); zz[k] = 1'($urandom); ff[k] = 3'($urandom);
      if (k < 256) g = step(g, dword(rr[k], zz[k], ff[k]));
    end
    do_start(8'd0, g);
    d0 = dcnt;
    for (int k = 0; k < 257; k++) put(rr[k], zz[k], ff[k]);
    idle(2);
    chk("burst_done_count", dcnt - d0, 1);
    chk("burst_cnt", sample_cnt, 256);
    chk("burst_sig", signature, g);
    chk("burst_pass", pass, 1);
    chk("burst_busy", busy, 0);

    idle(2);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sig_analyzer.md
ALU_SIG_ANALYZER -- requirements
Module: alu_sig_analyzer

Interface
REQ-001 SHALL have parameter SEED, default 16'hFFFF, MISR value loaded at start.
REQ-002 SHALL have parameter POLY, default 16'h1021, MISR feedback taps (x^16+x^12+x^5+1).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a capture run.
REQ-006 SHALL have port num_vec  input  8  samples per run; 0 means 256.
REQ-007 SHALL have port golden_sig  input  16  expected signature for the run.
REQ-008 SHALL have port sample_valid  input  1  ALU result/flag/func valid this cycle.
REQ-009 SHALL have port alu_result  input  16  ALU result bus (ALUR_out).
REQ-010 SHALL have port alu_zf  input  1  ALU zero flag.
REQ-011 SHALL have port func  input  3  ALU function code that produced the result.
REQ-012 SHALL have port busy  output  1  high in RUN and CHECK states.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a run completes.
REQ-014 SHALL have port pass  output  1  final signature equalled golden; held until next start.
REQ-015 SHALL have port signature  output  16  current MISR value.
REQ-016 SHALL have port sample_cnt  output  9  samples accepted in current/last run.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, CHECK.
REQ-018 In IDLE, start SHALL: load signature=SEED, sample_cnt=0, pass=0, latch golden_sig and num_vec (0 -> 256), go RUN next cycle.
REQ-019 In RUN, each cycle with sample_valid=1 SHALL accept one sample; cycles with sample_valid=0 SHALL leave signature and sample_cnt unchanged.
REQ-020 Input word SHALL be d = alu_result XOR {func, 12'h000, alu_zf} (func in bits 15:13, zf in bit 0).
REQ-021 MISR update SHALL be sig_next = {sig[14:0],1'b0} XOR (sig[15] ? POLY : 0) XOR d, modulo 2^16.
REQ-022 On the accepted sample that makes sample_cnt equal the latched count, FSM SHALL go CHECK next cycle; no further samples accepted.
REQ-023 In CHECK (one cycle), SHALL assert done=1, set pass=(signature==latched golden), return to IDLE next cycle.
REQ-024 done SHALL therefore rise exactly one cycle after the final sample edge.
REQ-025 start while busy=1 SHALL be ignored; golden_sig/num_vec changes during a run SHALL have no effect.
REQ-026 sample_valid in IDLE or CHECK SHALL be ignored.
REQ-027 signature and sample_cnt SHALL hold their final values in IDLE until the next start.
REQ-028 sample_cnt SHALL never exceed 256.

Reset
REQ-029 On clk edge with rst_n=0: state=IDLE, signature=SEED, sample_cnt=0, busy=0, done=0, pass=0, latched golden/count cleared.
REQ-030 Reset mid-RUN or mid-CHECK SHALL abort the run with no done pulse.

Structure
REQ-031 Shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, CHECK=2'd2), default SEED/POLY and width constants (16-bit data, 3-bit func).
REQ-032 MISR next-state logic SHALL be one combinational sub-module, misr16_step (inputs sig, d; output sig_next).

Verification
REQ-033 num_vec=1, golden=EFDD, one sample result=0x0002, zf=0, func=000 -> signature=EFDD, done pulse next cycle, pass=1.
REQ-034 num_vec=1, golden=CFDE, sample result=0x0000, zf=1, func=001 -> signature=CFDE, pass=1; rerun with golden=CFDF -> pass=0.
REQ-035 num_vec=2, samples separated by 3 idle sample_valid=0 cycles -> sample_cnt stays 1 during gap, done only after second sample.
REQ-036 start pulsed mid-run with different golden -> ignored; result matches first golden; busy never drops early.
REQ-037 rst_n=0 for one cycle after 1 of 4 samples -> busy=0, signature=FFFF, sample_cnt=0, no done.
REQ-038 num_vec=0 with 256 valid samples -> done after 256th, sample_cnt=256; 257th sample ignored.
